// File: rtl/bp_vc_buffered.sv
// Victim cache between the D$ eviction path and the UCE writeback path.
// Compacted FIFO-aged storage, registered lookup, one-entry writeback register, flush drain.
module bp_vc_buffered #(
  parameter int unsigned block_width = 512,
  parameter int unsigned tag_width   = 28,
  parameter int unsigned stat_width  = 2,
  parameter int unsigned num_entries = 4,
  parameter logic [stat_width-1:0] dirty_mask = stat_width'(2'b10)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               evict_v_i,
  output logic                               evict_ready_o,
  input  logic [block_width-1:0]             evict_data_i,
  input  logic [tag_width-1:0]               evict_tag_i,
  input  logic [stat_width-1:0]              evict_stat_i,
  input  logic                               lookup_v_i,
  input  logic [tag_width-1:0]               lookup_tag_i,
  input  logic                               lookup_remove_i,
  output logic                               hit_v_o,
  output logic                               hit_o,
  output logic [block_width-1:0]             hit_data_o,
  output logic [stat_width-1:0]              hit_stat_o,
  output logic                               wb_v_o,
  input  logic                               wb_ready_i,
  output logic [block_width-1:0]             wb_data_o,
  output logic [tag_width-1:0]               wb_tag_o,
  output logic [stat_width-1:0]              wb_stat_o,
  input  logic                               flush_i,
  output logic                               flush_done_o,
  output logic [$clog2(num_entries+1)-1:0]   count_o
);

  localparam int unsigned cnt_w = $clog2(num_entries + 1);
  localparam int unsigned idx_w = $clog2(num_entries);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_e;

  state_e state_q, state_d;

  logic [block_width-1:0] data_q [num_entries];
  logic [tag_width-1:0]   tag_q  [num_entries];
  logic [stat_width-1:0]  stat_q [num_entries];
  logic [block_width-1:0] data_d [num_entries];
  logic [tag_width-1:0]   tag_d  [num_entries];
  logic [stat_width-1:0]  stat_d [num_entries];
  logic [cnt_w-1:0]       count_q, count_d, k;

  logic [num_entries-1:0] valid, lk_match, dup_match, lk_rm, rm;
  logic [idx_w-1:0]       lk_idx;
  logic                   lk_hit;
  logic                   oldest_dirty, full_after, wb_free, ins, disp, pop, wb_load;

  logic                   hit_v_q, hit_q;
  logic [block_width-1:0] hit_data_q;
  logic [stat_width-1:0]  hit_stat_q;

  logic                   wb_v_q;
  logic [block_width-1:0] wb_data_q;
  logic [tag_width-1:0]   wb_tag_q;
  logic [stat_width-1:0]  wb_stat_q;

  // Slot validity follows from compaction: slots below count are live.
  always_comb begin
    valid     = '0;
    lk_match  = '0;
    dup_match = '0;
    lk_idx    = '0;
    for (int i = 0; i < int'(num_entries); i++) begin
      valid[i]     = (32'(i) < 32'(count_q));
      lk_match[i]  = lookup_v_i & valid[i] & (tag_q[i] == lookup_tag_i);
      dup_match[i] = valid[i] & (tag_q[i] == evict_tag_i);
      if (lk_match[i]) lk_idx = idx_w'(i);
    end
    lk_hit = |lk_match;
  end

  // Admission and removal decisions for this cycle.
  always_comb begin
    lk_rm         = lk_match & {num_entries{lookup_remove_i}};
    oldest_dirty  = (stat_q[0] & dirty_mask) != '0;
    wb_free       = ~wb_v_q | wb_ready_i;
    full_after    = (count_q == cnt_w'(num_entries)) && ((lk_rm | dup_match) == '0);
    evict_ready_o = (state_q == IDLE) & ~(full_after & oldest_dirty & ~wb_free);
    ins           = evict_v_i & evict_ready_o;
    disp          = ins & full_after;
    pop           = (state_q == FLUSH) & (count_q != '0) & (~oldest_dirty | wb_free);
    wb_load       = (disp | pop) & oldest_dirty;
    rm            = lk_rm | (ins ? dup_match : '0) | {{(num_entries-1){1'b0}}, disp | pop};
  end

  // Compact survivors toward slot 0, then append the new entry as youngest.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    stat_d = stat_q;
    k      = '0;
    for (int i = 0; i < int'(num_entries); i++) begin
      if (valid[i] && !rm[i]) begin
        data_d[idx_w'(k)] = data_q[i];
        tag_d[idx_w'(k)]  = tag_q[i];
        stat_d[idx_w'(k)] = stat_q[i];
        k = k + cnt_w'(1);
      end
    end
    if (ins) begin
      data_d[idx_w'(k)] = evict_data_i;
      tag_d[idx_w'(k)]  = evict_tag_i;
      stat_d[idx_w'(k)] = evict_stat_i;
      k = k + cnt_w'(1);
    end
    count_d = k;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_i) state_d = FLUSH;
      FLUSH:   if ((count_q == '0) && !wb_v_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      hit_v_q    <= 1'b0;
      hit_q      <= 1'b0;
      hit_data_q <= '0;
      hit_stat_q <= '0;
      wb_v_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hit_v_q    <= lookup_v_i;
      hit_q      <= lk_hit;
      hit_data_q <= lk_hit ? data_q[lk_idx] : '0;
      hit_stat_q <= lk_hit ? stat_q[lk_idx] : '0;
      if (wb_load)         wb_v_q <= 1'b1;
      else if (wb_ready_i) wb_v_q <= 1'b0;
    end
  end

  // Payload storage carries no reset; validity lives in count_q and wb_v_q.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    tag_q  <= tag_d;
    stat_q <= stat_d;
    if (wb_load) begin
      wb_data_q <= data_q[0];
      wb_tag_q  <= tag_q[0];
      wb_stat_q <= stat_q[0];
    end
  end

  assign hit_v_o      = hit_v_q;
  assign hit_o        = hit_q;
  assign hit_data_o   = hit_data_q;
  assign hit_stat_o   = hit_stat_q;
  assign wb_v_o       = wb_v_q;
  assign wb_data_o    = wb_data_q;
  assign wb_tag_o     = wb_tag_q;
  assign wb_stat_o    = wb_stat_q;
  assign flush_done_o = (state_q == DONE);
  assign count_o      = count_q;

endmodule

// File: tb/tb_bp_vc_buffered.sv
// Randomized and directed bench for bp_vc_buffered against a queue-based victim cache model.
module tb_bp_vc_buffered;

  localparam int BW = 512;
  localparam int TW = 28;
  localparam int SW = 2;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [BW-1:0] data;
    logic [SW-1:0] stat;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          evict_v = 1'b0, evict_ready;
  logic [BW-1:0] evict_data = '0;
  logic [TW-1:0] evict_tag = '0;
  logic [SW-1:0] evict_stat = '0;
  logic          lookup_v = 1'b0, lookup_remove = 1'b0;
  logic [TW-1:0] lookup_tag = '0;
  logic          hit_v, hit;
  logic [BW-1:0] hit_data;
  logic [SW-1:0] hit_stat;
  logic          wb_v, wb_ready = 1'b0;
  logic [BW-1:0] wb_data;
  logic [TW-1:0] wb_tag;
  logic [SW-1:0] wb_stat;
  logic          flush = 1'b0, flush_done;
  logic [CW-1:0] count;

  bp_vc_buffered dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .evict_v_i(evict_v), .evict_ready_o(evict_ready), .evict_data_i(evict_data),
    .evict_tag_i(evict_tag), .evict_stat_i(evict_stat),
    .lookup_v_i(lookup_v), .lookup_tag_i(lookup_tag), .lookup_remove_i(lookup_remove),
    .hit_v_o(hit_v), .hit_o(hit), .hit_data_o(hit_data), .hit_stat_o(hit_stat),
    .wb_v_o(wb_v), .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_tag_o(wb_tag),
    .wb_stat_o(wb_stat), .flush_i(flush), .flush_done_o(flush_done), .count_o(count)
  );

  always #5 clk = ~clk;

  // Reference model state: age-ordered queue, writeback slot, flush mode (0 idle, 1 flush, 2 done).
  ent_t          q[$];
  bit            m_wb_v;
  ent_t          m_wb;
  int            m_mode;
  bit            e_hit_v, e_hit;
  logic [BW-1:0] e_hit_data;
  logic [SW-1:0] e_hit_stat;

  int            n_cmp = 0, n_bad = 0;
  int            wb_xfers, done_pulses;
  logic [TW-1:0] wb_tags[$];

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_dirty(input logic [SW-1:0] s);
    return (s & 2'b10) != 2'b00;
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic model_clear();
    q.delete();
    m_wb_v     = 1'b0;
    m_mode     = 0;
    e_hit_v    = 1'b0;
    e_hit      = 1'b0;
    e_hit_data = '0;
    e_hit_stat = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    evict_v = 1'b0; lookup_v = 1'b0; lookup_remove = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    #1;
    check("rst_count", BW'(count), BW'(0));
    check("rst_wb_v", BW'(wb_v), BW'(0));
    check("rst_hit_v", BW'(hit_v), BW'(0));
    check("rst_hit", BW'(hit), BW'(0));
    check("rst_flush_done", BW'(flush_done), BW'(0));
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock: drive at negedge, check combinational/pre-edge outputs, advance model, check post-edge.
  task automatic step(input bit ev, input logic [TW-1:0] et, input logic [BW-1:0] ed,
                      input logic [SW-1:0] es, input bit lv, input logic [TW-1:0] lt,
                      input bit lr, input bit wr, input bit fl);
    int   hi, di;
    bit   full_after, wb_free, rdy, acc, pop, nwbv;
    ent_t nwb, ne, d;
    ent_t nq[$];
    @(negedge clk);
    evict_v = ev; evict_tag = et; evict_data = ed; evict_stat = es;
    lookup_v = lv; lookup_tag = lt; lookup_remove = lr; wb_ready = wr; flush = fl;
    #1;
    hi = -1; di = -1;
    foreach (q[i]) begin
      if (lv && q[i].tag == lt) hi = i;
      if (q[i].tag == et) di = i;
    end
    full_after = (q.size() == N) && !(hi >= 0 && lr) && (di < 0);
    wb_free    = !m_wb_v || wr;
    rdy        = (m_mode == 0) && !(full_after && is_dirty(q[0].stat) && !wb_free);
    check("evict_ready", BW'(evict_ready), BW'(rdy));
    check("wb_v_pre", BW'(wb_v), BW'(m_wb_v));
    if (m_wb_v) begin
      check("wb_tag", BW'(wb_tag), BW'(m_wb.tag));
      check("wb_data", wb_data, m_wb.data);
      check("wb_stat", BW'(wb_stat), BW'(m_wb.stat));
      if (wr) begin
        wb_xfers++;
        wb_tags.push_back(m_wb.tag);
      end
    end
    acc  = ev && rdy;
    pop  = (m_mode == 1) && (q.size() > 0) && (!is_dirty(q[0].stat) || wb_free);
    nwbv = m_wb_v && !wr;
    nwb  = m_wb;
    if (pop && is_dirty(q[0].stat)) begin
      nwbv = 1'b1;
      nwb  = q[0];
    end
    foreach (q[i])
      if (!((i == hi && lr) || (acc && i == di) || (pop && i == 0))) nq.push_back(q[i]);
    if (acc) begin
      if (nq.size() == N) begin
        d = nq.pop_front();
        if (is_dirty(d.stat)) begin
          nwbv = 1'b1;
          nwb  = d;
        end
      end
      ne.tag = et; ne.data = ed; ne.stat = es;
      nq.push_back(ne);
    end
    e_hit_v    = lv;
    e_hit      = hi >= 0;
    e_hit_data = (hi >= 0) ? q[hi].data : '0;
    e_hit_stat = (hi >= 0) ? q[hi].stat : '0;
    case (m_mode)
      0:       m_mode = fl ? 1 : 0;
      1:       m_mode = (q.size() == 0 && !m_wb_v) ? 2 : 1;
      default: m_mode = 0;
    endcase
    @(posedge clk);
    q      = nq;
    m_wb_v = nwbv;
    m_wb   = nwb;
    #1;
    check("count", BW'(count), BW'(q.size()));
    check("hit_v", BW'(hit_v), BW'(e_hit_v));
    check("hit", BW'(hit), BW'(e_hit));
    check("hit_data", hit_data, e_hit_data);
    check("hit_stat", BW'(hit_stat), BW'(e_hit_stat));
    check("flush_done", BW'(flush_done), BW'(m_mode == 2));
    check("wb_v_post", BW'(wb_v), BW'(m_wb_v));
    if (flush_done) done_pulses++;
  endtask

  task automatic ins(input logic [TW-1:0] t, input logic [SW-1:0] s);
    step(1'b1, t, rand_blk(), s, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic look(input logic [TW-1:0] t, input bit r);
    step(1'b0, '0, '0, '0, 1'b1, t, r, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] t;
    int            r;
    do_reset();

    // Fill with clean blocks and hit on a middle entry.
    for (int i = 0; i < 4; i++) ins(TW'(32'h10 + i), 2'b00);
    check("fill_count", BW'(count), BW'(4));
    look(TW'(32'h12), 1'b0);
    check("fill_hit", BW'(hit), BW'(1));

    // Dirty displacement into a stalled wb register, then back-pressure on the next one.
    do_reset();
    ins(TW'(32'h10), 2'b10);
    ins(TW'(32'h11), 2'b10);
    ins(TW'(32'h12), 2'b00);
    ins(TW'(32'h13), 2'b00);
    ins(TW'(32'h20), 2'b00);
    check("disp_wb_tag", BW'(wb_tag), BW'(32'h10));
    for (int i = 0; i < 3; i++) step(1'b1, TW'(32'h21), rand_blk(), 2'b00, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("stall_ready", BW'(evict_ready), BW'(0));
    step(1'b1, TW'(32'h21), rand_blk(), 2'b00, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("reload_wb_tag", BW'(wb_tag), BW'(32'h11));

    // Full + lookup-remove + insert in the same cycle, then duplicate replacement.
    do_reset();
    for (int i = 0; i < 4; i++) ins(TW'(32'h10 + i), 2'b00);
    step(1'b1, TW'(32'h30), rand_blk(), 2'b10, 1'b1, TW'(32'h12), 1'b1, 1'b0, 1'b0);
    check("rm_ins_count", BW'(count), BW'(4));
    check("rm_ins_nowb", BW'(wb_v), BW'(0));
    ins(TW'(32'h11), 2'b10);
    look(TW'(32'h11), 1'b0);
    look(TW'(32'h30), 1'b0);

    // Flush with mixed dirty/clean and an alternating wb_ready.
    do_reset();
    ins(TW'(32'h10), 2'b10);
    ins(TW'(32'h11), 2'b00);
    ins(TW'(32'h12), 2'b10);
    ins(TW'(32'h13), 2'b00);
    wb_xfers = 0; done_pulses = 0; wb_tags.delete();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40 && m_mode != 0; i++)
      step(1'b1, TW'(32'h50), rand_blk(), 2'b10, 1'b0, '0, 1'b0, (i % 2) == 0, 1'b0);
    check("flush_xfers", BW'(wb_xfers), BW'(2));
    check("flush_pulses", BW'(done_pulses), BW'(1));
    check("flush_count", BW'(count), BW'(0));
    if (wb_tags.size() == 2) begin
      check("flush_tag0", BW'(wb_tags[0]), BW'(32'h10));
      check("flush_tag1", BW'(wb_tags[1]), BW'(32'h12));
    end else begin
      check("flush_tag_count", BW'(wb_tags.size()), BW'(2));
    end

    // Reset in the middle of a stalled flush.
    do_reset();
    for (int i = 0; i < 4; i++) ins(TW'(32'h10 + i), 2'b10);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("midflush_wb_v", BW'(wb_v), BW'(1));
    do_reset();
    look(TW'(32'h11), 1'b0);
    check("post_rst_miss", BW'(hit), BW'(0));

    // Randomized traffic over a small tag space to force hits, duplicates and displacements.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      t = TW'(32'h40 + $urandom_range(0, 7));
      r = $urandom_range(0, 99);
      step($urandom_range(0, 99) < 60, t, rand_blk(), SW'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 50, TW'(32'h40 + $urandom_range(0, 7)),
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 50, r < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
